// File: rtl/arith_pkg.sv
// arith_pkg
// Shared definitions for the arithmetic arbiter slice: operation encoding,
// FSM state encoding and the default operand/result widths.
// No ports (package).

package arith_pkg;

    // Default operand width and the matching zero-extended result width.
    localparam int ARITH_DW = 3;
    localparam int ARITH_RW = 2 * ARITH_DW;

    // Operation encoding on req_op; codes 5..7 are illegal.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/arith_divider.sv
// arith_divider
// Iterative restoring divider, one quotient bit per clock, DW iterations.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load dividend/divisor and begin a division
//   dividend, divisor unsigned DW-bit operands (divisor assumed non-zero)
//   done              high in the cycle whose rising edge retires the last
//                     iteration; quotient/remainder are final after that edge
//   quotient          DW-bit quotient, held until the next start
//   remainder         DW-bit remainder, held until the next start

module arith_divider
    import arith_pkg::*;
#(
    parameter int DW = ARITH_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] quo_q;
    logic [DW-1:0] rem_q;
    logic [DW-1:0] dvs_q;
    logic [CW-1:0] count_q;
    logic          busy_q;
    logic [DW:0]   rem_shift;
    logic [DW:0]   trial;

    // Shift the next dividend bit into the partial remainder and try the
    // subtraction; a borrow (MSB set) means the trial must be discarded.
    always_comb begin
        rem_shift = {rem_q, quo_q[DW-1]};
        trial     = rem_shift - {1'b0, dvs_q};
    end

    // The quotient register doubles as the dividend shift register: dividend
    // bits leave from the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            quo_q   <= dividend;
            rem_q   <= '0;
            dvs_q   <= divisor;
            count_q <= CW'(DW);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            if (trial[DW]) begin
                rem_q <= rem_shift[DW-1:0];
                quo_q <= {quo_q[DW-2:0], 1'b0};
            end else begin
                rem_q <= trial[DW-1:0];
                quo_q <= {quo_q[DW-2:0], 1'b1};
            end
            count_q <= count_q - 1'b1;
            if (count_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Flagged one cycle early so the controller can leave its divide state on
    // the same edge that produces the final quotient bit.
    assign done      = busy_q && (count_q == CW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/arith_arbiter.sv
// arith_arbiter
// Two-requester round-robin arbiter in front of a small arithmetic unit.
// ADD/SUB/MUL finish in one EXEC cycle; DIV/MOD use the iterative divider.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[i]            request from requester i
//   req_ready[i]            request from requester i accepted this cycle
//   req_op[i]               operation code (see arith_pkg::op_e)
//   req_a[i], req_b[i]      unsigned operands
//   rsp_valid / rsp_ready   response handshake
//   rsp_id                  requester owning the response
//   rsp_result              zero-extended result
//   rsp_err                 illegal op or divide/modulo by zero

module arith_arbiter
    import arith_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DW    = ARITH_DW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0][2:0]     req_op,
    input  logic [N_REQ-1:0][DW-1:0]  req_a,
    input  logic [N_REQ-1:0][DW-1:0]  req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_id,
    output logic [2*DW-1:0]           rsp_result,
    output logic                      rsp_err
);

    localparam int RW = 2 * DW;

    state_e           state, state_next;
    logic [N_REQ-1:0] grant;
    logic             grant_id;
    logic             rr_last;
    logic             accept;
    logic [2:0]       sel_op;
    logic [DW-1:0]    sel_a;
    logic [DW-1:0]    sel_b;
    logic             sel_div;

    logic [2:0]       op_q;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic             id_q;
    logic             use_div_q;
    logic [RW-1:0]    result_q;
    logic             err_q;

    logic [DW:0]      sum;
    logic [DW-1:0]    diff;
    logic [RW-1:0]    prod;
    logic [RW-1:0]    exec_result;
    logic             exec_err;

    logic             div_done;
    logic [DW-1:0]    div_quo;
    logic [DW-1:0]    div_rem;

    // Round-robin choice: under contention the requester not served last
    // wins, otherwise whichever one is asking. rr_last resets to 1 so that
    // requester 0 wins the first contention.
    always_comb begin
        grant    = '0;
        grant_id = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            grant_id = ~rr_last;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
        if (req_valid[grant_id]) begin
            grant[grant_id] = 1'b1;
        end
        sel_op  = req_op[grant_id];
        sel_a   = req_a[grant_id];
        sel_b   = req_b[grant_id];
        sel_div = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b != '0);
    end

    // Reset gates ready explicitly: the state already reads IDLE during
    // reset, yet nothing may be offered until reset is released.
    assign req_ready = (state == S_IDLE && rst_n) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = sel_div ? S_DIV : S_EXEC;
            S_EXEC: state_next = S_RESP;
            S_DIV:  if (div_done) state_next = S_RESP;
            S_RESP: if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle operations. DIV/MOD only reach EXEC with a zero divisor,
    // so they land in the error default together with the illegal codes.
    always_comb begin
        sum         = {1'b0, a_q} + {1'b0, b_q};
        diff        = a_q - b_q;
        prod        = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
        exec_result = '0;
        exec_err    = 1'b0;
        case (op_q)
            OP_ADD:  exec_result = {{(RW-DW-1){1'b0}}, sum};
            OP_SUB:  exec_result = {{DW{1'b0}}, diff};
            OP_MUL:  exec_result = prod;
            default: exec_err    = 1'b1;
        endcase
    end

    // Capture the granted request on acceptance; the EXEC result is
    // registered so it stays stable for the whole response phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            use_div_q <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
            rr_last   <= 1'b1;
        end else if (accept) begin
            op_q      <= sel_op;
            a_q       <= sel_a;
            b_q       <= sel_b;
            id_q      <= grant_id;
            use_div_q <= sel_div;
            result_q  <= '0;
            err_q     <= 1'b0;
            rr_last   <= grant_id;
        end else if (state == S_EXEC) begin
            result_q  <= exec_result;
            err_q     <= exec_err;
        end
    end

    arith_divider #(
        .DW (DW)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept && sel_div),
        .dividend  (sel_a),
        .divisor   (sel_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Response fields are forced to zero outside RESP; the divider holds its
    // outputs after finishing, so its results can be read directly.
    always_comb begin
        rsp_valid  = (state == S_RESP);
        rsp_id     = rsp_valid && id_q;
        rsp_err    = rsp_valid && err_q;
        rsp_result = '0;
        if (rsp_valid) begin
            if (use_div_q) begin
                rsp_result = {{DW{1'b0}}, (op_q == OP_MOD) ? div_rem : div_quo};
            end else begin
                rsp_result = result_q;
            end
        end
    end

endmodule

// File: doc/arith_arbiter.md
ARITH_ARBITER -- requirements
Module: arith_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters (fixed at 2 for this revision).
REQ-002 SHALL have parameter DW, default 3, operand width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports req_valid[i]  input  1  per requester i: operation request.
REQ-006 SHALL have ports req_ready[i]  output  1  per requester i: request accepted this cycle.
REQ-007 SHALL have ports req_op[i]  input  3  per requester i: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5-7 illegal.
REQ-008 SHALL have ports req_a[i], req_b[i]  input  DW  per requester i: unsigned operands.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-012 SHALL have port rsp_result  output  2*DW  result, zero-extended.
REQ-013 SHALL have port rsp_err  output  1  illegal op or divide/modulo by zero.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DIV, RESP.
REQ-015 In IDLE, req_ready SHALL be high only for the granted requester; in every other state all req_ready SHALL be low.
REQ-016 Grant SHALL be round-robin: if both req_valid are high, grant the requester not served last; if one is high, grant it.
REQ-017 On acceptance (req_valid & req_ready), operands, op and id SHALL be captured. Next state: DIV for legal DIV/MOD with b!=0, EXEC otherwise.
REQ-018 EXEC SHALL last one cycle and compute the result:
- ADD = a+b (DW+1 bits);
- SUB = (a-b) mod 2^DW;
- MUL = a*b (2*DW bits).
REQ-019 DIV SHALL run a restoring divide for exactly DW cycles and produce quotient (DIV) or remainder (MOD).
REQ-020 Illegal op or b==0 with DIV/MOD SHALL go to EXEC and set rsp_err=1, rsp_result=0.
REQ-021 Latency from the acceptance edge to rsp_valid high SHALL be 1 cycle for EXEC paths and DW cycles for DIV paths.
REQ-022 In RESP, rsp_valid, rsp_id, rsp_result and rsp_err SHALL be held stable until rsp_ready=1, then return to IDLE.
REQ-023 No new request SHALL be accepted in the cycle the response handshakes; acceptance resumes the following cycle.
REQ-024 The round-robin pointer SHALL update only on acceptance.
REQ-025 Requests deasserted before acceptance SHALL be dropped without side effects.

Reset
REQ-026 While rst_n=0, the block SHALL be in state IDLE.
REQ-027 While rst_n=0, rsp_valid, rsp_id, rsp_result and rsp_err SHALL be 0.
REQ-028 While rst_n=0, all req_ready SHALL be 0.
REQ-029 Reset SHALL set the round-robin pointer so requester 0 wins the first contention.
REQ-030 Reset asserted mid-EXEC, mid-DIV or mid-RESP SHALL discard the operation; no response SHALL be produced after release.

Structure
REQ-031 Package arith_pkg SHALL hold the op encoding enum, FSM state enum, DW and result-width constants.
REQ-032 Sub-module arith_divider SHALL implement the iterative restoring divider (start, done, quotient, remainder), reset by rst_n.

Verification
REQ-033 Req0 ADD a=7 b=7, rsp_ready=1 -> rsp_valid 1 cycle after accept, result=14, id=0, err=0.
REQ-034 Req1 SUB a=2 b=5 -> result=5, err=0; then MUL a=7 b=7 -> result=49.
REQ-035 Req0 DIV a=5 b=2 -> rsp_valid 3 cycles after accept, result=2; MOD a=5 b=2 -> result=1.
REQ-036 DIV a=6 b=0 -> err=1, result=0, latency 1; op=6 -> err=1, result=0.
REQ-037 Both requesters valid continuously after reset -> grants 0,1,0,1; rsp_ready held low 5 cycles -> response stable, no req_ready.
REQ-038 rst_n pulsed low during DIV cycle 2 -> no rsp_valid afterwards, outputs 0, next contention granted to requester 0.
